pixel_coord_gen: RTL and testbench

PIXEL_COORD_GEN -- requirements
Module: pixel_coord_gen

---
 rtl/pixel_coord_gen.sv | 196 +++++++++++++++++++
 tb/tb_pixel_coord_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_coord_gen.sv
// Streams fixed-point complex-plane coordinates for every pixel of a frame.
// Per-frame steps come from a shared restoring divider; pixels use adds only.
module pixel_coord_gen #(
    parameter int WORD_LENGTH   = 32,
    parameter int FRAC          = 28,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int LANES         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_LENGTH-1:0]         zoom,
    input  logic [WORD_LENGTH-1:0]         real_center,
    input  logic [WORD_LENGTH-1:0]         imag_center,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*WORD_LENGTH-1:0]   out_real,
    output logic [WORD_LENGTH-1:0]         out_imag,
    output logic [10:0]                    out_x,
    output logic [10:0]                    out_y,
    output logic                           out_sof,
    output logic                           out_eol,
    output logic                           out_eof,
    output logic                           busy,
    output logic                           cfg_err
);
    localparam int WL = WORD_LENGTH;
    localparam int NW = 2 * FRAC + 2;
    localparam int DW = WL + 11;
    localparam int RW = ((NW > DW) ? NW : DW) + 1;
    localparam int CW = $clog2(WL);
    localparam logic [RW-1:0] NUM_RE = RW'(3) << (2 * FRAC);
    localparam logic [RW-1:0] NUM_IM = RW'(2) << (2 * FRAC);
    localparam logic [10:0]   LAST_X = 11'(SCREEN_WIDTH - LANES);
    localparam logic [10:0]   LAST_Y = 11'(SCREEN_HEIGHT - 1);
    localparam logic [WL-1:0] QMAX   = {1'b0, {(WL-1){1'b1}}};

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DIV_RE = 3'd1;
    localparam logic [2:0] DIV_IM = 3'd2;
    localparam logic [2:0] ORIGIN = 3'd3;
    localparam logic [2:0] STREAM = 3'd4;

    logic [2:0]          state;
    logic [WL-1:0]       zoom_r, re_c_r, im_c_r, step_re, step_im, real_min;
    logic [RW-1:0]       rem, num, dvs, r0, rem_n;
    logic [RW:0]         trial;
    logic [WL-1:0]       num_lo, lo0, quo_n, q_sat;
    logic [WL-2:0]       quo;
    logic                ovf, ov0, qbit;
    logic [CW-1:0]       cnt;
    logic [WL-1:0]       real_min_c, imag_max_c, row_base, stride;
    logic [LANES*WL-1:0] row_load, lane_adv;
    logic [10:0]         x_nxt;
    logic                eol_nxt;

    // The first cycle of each division seeds the remainder with the numerator's
    // upper half; a seed already >= divisor means the quotient cannot fit.
    always_comb begin
        num   = (state == DIV_IM) ? NUM_IM : NUM_RE;
        dvs   = RW'(zoom_r) * RW'((state == DIV_IM) ? SCREEN_HEIGHT - 1 : SCREEN_WIDTH - 1);
        r0    = (cnt == '0) ? (num >> WL) : rem;
        lo0   = (cnt == '0) ? num[WL-1:0] : num_lo;
        ov0   = (cnt == '0) ? ((num >> WL) >= dvs) : ovf;
        trial = {r0, lo0[WL-1]};
        qbit  = !ov0 && (trial >= {1'b0, dvs});
        rem_n = qbit ? RW'(trial - {1'b0, dvs}) : trial[RW-1:0];
        quo_n = {quo, qbit};
        q_sat = (ov0 || quo_n[WL-1]) ? QMAX : quo_n;
    end

    always_comb begin
        real_min_c = re_c_r - WL'(SCREEN_WIDTH / 2) * step_re;
        imag_max_c = im_c_r + WL'(SCREEN_HEIGHT / 2) * step_im;
        row_base   = (state == ORIGIN) ? real_min_c : real_min;
        stride     = WL'(LANES) * step_re;
        row_load   = '0;
        lane_adv   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            row_load[k*WL +: WL] = row_base + WL'(k) * step_re;
            lane_adv[k*WL +: WL] = out_real[k*WL +: WL] + stride;
        end
        x_nxt   = out_x + 11'(LANES);
        eol_nxt = (x_nxt == LAST_X);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            zoom_r    <= '0;
            re_c_r    <= '0;
            im_c_r    <= '0;
            step_re   <= '0;
            step_im   <= '0;
            real_min  <= '0;
            rem       <= '0;
            num_lo    <= '0;
            quo       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (zoom == '0) begin
                                cfg_err <= 1'b1;
                            end else begin
                                zoom_r <= zoom;
                                re_c_r <= real_center;
                                im_c_r <= imag_center;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= DIV_RE;
                            end
                        end
                    end
                    DIV_RE, DIV_IM: begin
                        rem    <= rem_n;
                        num_lo <= {lo0[WL-2:0], 1'b0};
                        ovf    <= ov0;
                        quo    <= quo_n[WL-2:0];
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(WL - 1)) begin
                            cnt <= '0;
                            if (state == DIV_RE) begin
                                step_re <= q_sat;
                                state   <= DIV_IM;
                            end else begin
                                step_im <= q_sat;
                                state   <= ORIGIN;
                            end
                        end
                    end
                    ORIGIN: begin
                        real_min  <= real_min_c;
                        out_real  <= row_load;
                        out_imag  <= imag_max_c;
                        out_x     <= '0;
                        out_y     <= '0;
                        out_valid <= 1'b1;
                        out_sof   <= 1'b1;
                        out_eol   <= (SCREEN_WIDTH == LANES);
                        out_eof   <= (SCREEN_WIDTH == LANES) && (SCREEN_HEIGHT == 1);
                        state     <= STREAM;
                    end
                    STREAM: begin
                        if (out_valid && out_ready) begin
                            out_sof <= 1'b0;
                            if (out_eof) begin
                                out_valid <= 1'b0;
                                out_eol   <= 1'b0;
                                out_eof   <= 1'b0;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end else if (out_eol) begin
                                out_real <= row_load;
                                out_imag <= out_imag - step_im;
                                out_x    <= '0;
                                out_y    <= out_y + 11'd1;
                                out_eol  <= (SCREEN_WIDTH == LANES);
                                out_eof  <= (SCREEN_WIDTH == LANES) && (out_y + 11'd1 == LAST_Y);
                            end else begin
                                out_real <= lane_adv;
                                out_x    <= x_nxt;
                                out_eol  <= eol_nxt;
                                out_eof  <= eol_nxt && (out_y == LAST_Y);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pixel_coord_gen.sv
// Self-checking bench for pixel_coord_gen: directed full-size checks plus
// randomized frames compared against a closed-form coordinate model.
module tb_pixel_coord_gen;
    localparam int FRAC = 28;

    logic clk = 1'b0;
    logic rst, abort, out_ready;
    logic [3:0] st;
    logic [31:0] zoom, rc, ic;

    logic [3:0] vld, sof, eol, eof, bsy, err;
    logic [3:0][10:0] xo, yo;
    logic [3:0][31:0] imo;
    logic [31:0]  re_a, re_c;
    logic [127:0] re_b, re_d;

    logic [1:0]   sel;
    logic         c_valid, c_busy, c_err, c_sof, c_eol, c_eof;
    logic [10:0]  c_x, c_y;
    logic [31:0]  c_imag;
    logic [127:0] c_real, c_meta;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(FRAC), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .LANES(1)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .abort(abort), .zoom(zoom), .real_center(rc),
        .imag_center(ic), .out_valid(vld[0]), .out_ready(out_ready), .out_real(re_a),
        .out_imag(imo[0]), .out_x(xo[0]), .out_y(yo[0]), .out_sof(sof[0]), .out_eol(eol[0]),
        .out_eof(eof[0]), .busy(bsy[0]), .cfg_err(err[0]));

    pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(FRAC), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .LANES(4)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .abort(abort), .zoom(zoom), .real_center(rc),
        .imag_center(ic), .out_valid(vld[1]), .out_ready(out_ready), .out_real(re_b),
        .out_imag(imo[1]), .out_x(xo[1]), .out_y(yo[1]), .out_sof(sof[1]), .out_eol(eol[1]),
        .out_eof(eof[1]), .busy(bsy[1]), .cfg_err(err[1]));

    pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(FRAC), .SCREEN_WIDTH(24), .SCREEN_HEIGHT(10), .LANES(1)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .abort(abort), .zoom(zoom), .real_center(rc),
        .imag_center(ic), .out_valid(vld[2]), .out_ready(out_ready), .out_real(re_c),
        .out_imag(imo[2]), .out_x(xo[2]), .out_y(yo[2]), .out_sof(sof[2]), .out_eol(eol[2]),
        .out_eof(eof[2]), .busy(bsy[2]), .cfg_err(err[2]));

    pixel_coord_gen #(.WORD_LENGTH(32), .FRAC(FRAC), .SCREEN_WIDTH(24), .SCREEN_HEIGHT(10), .LANES(4)) u_d (
        .clk(clk), .rst(rst), .start(st[3]), .abort(abort), .zoom(zoom), .real_center(rc),
        .imag_center(ic), .out_valid(vld[3]), .out_ready(out_ready), .out_real(re_d),
        .out_imag(imo[3]), .out_x(xo[3]), .out_y(yo[3]), .out_sof(sof[3]), .out_eol(eol[3]),
        .out_eof(eof[3]), .busy(bsy[3]), .cfg_err(err[3]));

    always_comb begin
        c_valid = vld[sel];
        c_busy  = bsy[sel];
        c_err   = err[sel];
        c_sof   = sof[sel];
        c_eol   = eol[sel];
        c_eof   = eof[sel];
        c_x     = xo[sel];
        c_y     = yo[sel];
        c_imag  = imo[sel];
        case (sel)
            2'd0:    c_real = {96'b0, re_a};
            2'd1:    c_real = re_b;
            2'd2:    c_real = {96'b0, re_c};
            default: c_real = re_d;
        endcase
        c_meta = {71'b0, c_imag, c_x, c_y, c_sof, c_eol, c_eof};
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] s32(input int v);
        return {96'b0, 32'(v)};
    endfunction

    // Step = floor(mult * 2^(2*FRAC) / (zoom * n)), clamped to the largest positive word.
    function automatic logic [31:0] ref_step(input int mult, input logic [31:0] z, input int n);
        longint unsigned num, den, q;
        num = 64'(mult) << (2 * FRAC);
        den = 64'(z) * 64'(n);
        q = num / den;
        return (q >= 64'h8000_0000) ? 32'h7fff_ffff : q[31:0];
    endfunction

    function automatic logic [31:0] exp_re(input logic [31:0] z, input logic [31:0] c, input int w, input int x);
        logic [31:0] s;
        s = ref_step(3, z, w - 1);
        return c - 32'(w / 2) * s + 32'(x) * s;
    endfunction

    function automatic logic [31:0] exp_im(input logic [31:0] z, input logic [31:0] c, input int h, input int y);
        logic [31:0] s;
        s = ref_step(2, z, h - 1);
        return c + 32'(h / 2) * s - 32'(y) * s;
    endfunction

    task automatic run_frame(input logic [1:0] s, input int w, input int h, input int lanes,
                             input int stall_pct, input int max_beats);
        int bpr, total, limit, n, eofs, cyc, x0, y;
        bit prev_stall;
        logic [127:0] hold_re, hold_meta, e_re, e_meta;
        bpr = w / lanes;
        total = bpr * h;
        limit = (max_beats < total) ? max_beats : total;
        n = 0; eofs = 0; cyc = 0; prev_stall = 0;
        hold_re = '0; hold_meta = '0;
        sel = s;
        st[s] = 1'b1;
        tick();
        st[s] = 1'b0;
        while (n < limit && cyc < 4 * limit + 400) begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (prev_stall) check("valid_held", c_valid, 1);
            if (c_valid) begin
                if (prev_stall) begin
                    check("hold_re", c_real, hold_re);
                    check("hold_meta", c_meta, hold_meta);
                end
                if (out_ready) begin
                    x0 = (n % bpr) * lanes;
                    y = n / bpr;
                    e_re = '0;
                    for (int k = 0; k < lanes; k++) e_re[k*32 +: 32] = exp_re(zoom, rc, w, x0 + k);
                    e_meta = {71'b0, exp_im(zoom, ic, h, y), 11'(x0), 11'(y), n == 0,
                              x0 == w - lanes, (x0 == w - lanes) && (y == h - 1)};
                    check("beat_re", c_real, e_re);
                    check("beat_meta", c_meta, e_meta);
                    eofs += int'(c_eof);
                    n++;
                end
                prev_stall = !out_ready;
                hold_re = c_real;
                hold_meta = c_meta;
            end else begin
                prev_stall = 0;
            end
            tick();
            cyc++;
        end
        check("frame_beats", n, limit);
        if (limit == total) begin
            check("eof_count", eofs, 1);
            check("valid_after_eof", c_valid, 0);
            check("busy_after_eof", c_busy, 0);
        end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("valid_after_abort", c_valid, 0);
            check("busy_after_abort", c_busy, 0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1; st = '0; abort = 1'b0; out_ready = 1'b1;
        zoom = '0; rc = '0; ic = '0; sel = 2'd0;
        #3;
        check("rst_valid", c_valid, 0);
        check("rst_busy", c_busy, 0);
        check("rst_err", c_err, 0);
        check("rst_real", c_real, 0);
        check("rst_meta", c_meta, 0);
        #14 rst = 1'b0;
        tick();

        // Reference frame at unit zoom, centred on the origin.
        zoom = 32'h1000_0000;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        cyc = 1;
        check("busy_cycle1", c_busy, 1);
        while (!c_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("first_valid_cycle", cyc, 66);
        check("b0_real", c_real, s32(-403283200));
        check("b0_imag", {96'b0, c_imag}, s32(268995840));
        check("b0_sof", c_sof, 1);
        repeat (639) tick();
        check("b639_x", c_x, 639);
        check("b639_real", c_real, s32(402022940));
        check("b639_eol", c_eol, 1);
        tick();
        check("b640_imag", {96'b0, c_imag}, s32(267875024));
        check("b640_real", c_real, s32(-403283200));
        check("b640_xy", {c_x, c_y}, {11'd0, 11'd1});
        check("b640_eol", c_eol, 0);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        check("start_ignored_xy", {c_x, c_y}, {11'd1, 11'd1});
        check("start_ignored_valid", c_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_stream_valid", c_valid, 0);
        check("abort_stream_busy", c_busy, 0);

        // Abort while the divider is still running.
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_c10_busy", c_busy, 0);
        seen = 0;
        repeat (100) begin
            if (c_valid || c_busy) seen = 1;
            tick();
        end
        check("abort_c10_quiet", seen, 0);

        // Zero zoom is rejected.
        zoom = '0;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        check("cfg_err_pulse", c_err, 1);
        check("cfg_err_busy", c_busy, 0);
        tick();
        check("cfg_err_clear", c_err, 0);
        seen = 0;
        repeat (80) begin
            if (c_valid || c_busy || c_err) seen = 1;
            tick();
        end
        check("cfg_err_quiet", seen, 0);

        // Reset in the middle of streaming.
        zoom = 32'h1000_0000;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        cyc = 1;
        while (!c_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        repeat (20) tick();
        check("pre_rst_x", c_x, 20);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", c_valid, 0);
        check("rst_mid_real", c_real, 0);
        rst = 1'b0;
        seen = 0;
        repeat (100) begin
            tick();
            if (c_valid || c_busy) seen = 1;
        end
        check("rst_mid_quiet", seen, 0);

        // Four-lane full-size frame.
        sel = 2'd1;
        zoom = 32'h1000_0000; rc = '0; ic = '0;
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        cyc = 1;
        while (!c_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("l4_first_valid_cycle", cyc, 66);
        check("l4_b0_lane3", {96'b0, c_real[127:96]}, s32(-399502420));
        check("l4_b0_lane0", {96'b0, c_real[31:0]}, s32(-403283200));
        tick();
        check("l4_b1_x", c_x, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("l4_abort_valid", c_valid, 0);

        // Randomized frames with stalls.
        for (int f = 0; f < 6; f++) begin
            case (f % 3)
                0:       zoom = 32'($urandom_range(1, 4095));
                1:       zoom = 32'h1000_0000 + 32'($urandom_range(0, 65535));
                default: zoom = $urandom | 32'h0100_0000;
            endcase
            rc = $urandom;
            ic = $urandom;
            run_frame((f < 3) ? 2'd2 : 2'd3, 24, 10, (f < 3) ? 1 : 4, 40, 100000);
        end
        zoom = $urandom | 32'h0100_0000; rc = $urandom; ic = $urandom;
        run_frame(2'd0, 640, 480, 1, 30, 700);
        zoom = 32'($urandom_range(1, 65535)); rc = $urandom; ic = $urandom;
        run_frame(2'd1, 640, 480, 4, 30, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
